// File: rtl/msrh_ldq_multi.sv
// msrh_ldq_multi: parametrised load queue for the LSU cluster.
// Entries are allocated in program order, tracked through EX1/EX2 with
// per-pipe replay on TLB/L1D/LRQ/STQ hazards, and retired in order from head.
module msrh_ldq_multi #(
  parameter int DEPTH   = 8,
  parameter int DISP_W  = 2,
  parameter int PIPE_N  = 2,
  parameter int TAG_W   = 8,
  parameter int VADDR_W = 39,
  parameter int HAZ_W   = 4,
  parameter int IDX_W   = $clog2(DEPTH)
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic [DISP_W-1:0]         i_disp_valid,
  input  logic [DISP_W*TAG_W-1:0]   i_disp_tag,
  output logic                      o_disp_ready,
  output logic [DISP_W*IDX_W-1:0]   o_disp_idx,
  input  logic [PIPE_N-1:0]         i_ex1_valid,
  input  logic [PIPE_N*IDX_W-1:0]   i_ex1_idx,
  input  logic [PIPE_N*VADDR_W-1:0] i_ex1_vaddr,
  input  logic [PIPE_N-1:0]         i_ex1_tlb_miss,
  input  logic [PIPE_N-1:0]         i_ex1_exc,
  input  logic [PIPE_N-1:0]         i_ex2_valid,
  input  logic [PIPE_N*IDX_W-1:0]   i_ex2_idx,
  input  logic [PIPE_N*2-1:0]       i_ex2_haz,
  input  logic [PIPE_N*HAZ_W-1:0]   i_ex2_haz_oh,
  input  logic                      i_tlb_resolve,
  input  logic                      i_lrq_resolve_valid,
  input  logic [HAZ_W-1:0]          i_lrq_resolve_oh,
  input  logic                      i_stq_resolve_valid,
  input  logic [HAZ_W-1:0]          i_stq_resolve_oh,
  output logic [PIPE_N-1:0]         o_replay_valid,
  output logic [PIPE_N*IDX_W-1:0]   o_replay_idx,
  output logic [PIPE_N*VADDR_W-1:0] o_replay_vaddr,
  input  logic [PIPE_N-1:0]         i_replay_ready,
  output logic                      o_done_valid,
  output logic [TAG_W-1:0]          o_done_tag,
  output logic                      o_done_exc,
  input  logic                      i_flush,
  output logic [IDX_W:0]            o_count
);

  localparam int PTR_W  = IDX_W + 1;
  localparam int PIPE_W = (PIPE_N > 1) ? $clog2(PIPE_N) : 1;

  localparam logic [2:0] ST_FREE    = 3'd0;
  localparam logic [2:0] ST_WAIT    = 3'd1;
  localparam logic [2:0] ST_EX2_RUN = 3'd2;
  localparam logic [2:0] ST_TLB_HAZ = 3'd3;
  localparam logic [2:0] ST_LRQ_HAZ = 3'd4;
  localparam logic [2:0] ST_STQ_HAZ = 3'd5;
  localparam logic [2:0] ST_READY   = 3'd6;
  localparam logic [2:0] ST_DONE    = 3'd7;

  logic [2:0]         state_q  [DEPTH];
  logic [2:0]         state_d  [DEPTH];
  logic [TAG_W-1:0]   tag_q    [DEPTH];
  logic [PIPE_W-1:0]  pipe_q   [DEPTH];
  logic [VADDR_W-1:0] vaddr_q  [DEPTH];
  logic [HAZ_W-1:0]   haz_oh_q [DEPTH];
  logic [DEPTH-1:0]   exc_q;

  logic [PTR_W-1:0]   head_q;
  logic [PTR_W-1:0]   tail_q;
  logic [PTR_W-1:0]   count;
  logic [PTR_W-1:0]   free_cnt;
  logic [PTR_W-1:0]   disp_cnt;
  logic [PTR_W-1:0]   disp_ptr [DISP_W];
  logic [IDX_W-1:0]   head_idx;
  logic               alloc_en;

  logic [PIPE_N-1:0]  rep_valid;
  logic [PIPE_N-1:0]  rep_fire;
  logic [IDX_W-1:0]   rep_idx [PIPE_N];
  logic [IDX_W-1:0]   scan_idx;

  // Occupancy comes straight from the wrap-bit pointers; a slot freed by
  // retire this cycle is deliberately not visible to dispatch until next cycle.
  assign count        = tail_q - head_q;
  assign free_cnt     = PTR_W'(DEPTH) - count;
  assign o_count      = count;
  assign o_disp_ready = (free_cnt >= PTR_W'(DISP_W));
  assign alloc_en     = o_disp_ready & ~i_flush;
  assign head_idx     = head_q[IDX_W-1:0];

  // Retire reports the head entry whenever it has completed.
  assign o_done_valid = (state_q[head_idx] == ST_DONE);
  assign o_done_tag   = o_done_valid ? tag_q[head_idx] : '0;
  assign o_done_exc   = o_done_valid & exc_q[head_idx];

  // Per-lane allocation index and the number of lanes dispatching.
  always_comb begin
    disp_cnt   = '0;
    o_disp_idx = '0;
    for (int k = 0; k < DISP_W; k++) begin
      disp_ptr[k] = tail_q + PTR_W'(k);
      o_disp_idx[k*IDX_W +: IDX_W] = disp_ptr[k][IDX_W-1:0];
      if (i_disp_valid[k]) disp_cnt = disp_cnt + PTR_W'(1);
    end
  end

  // Oldest-first replay pick per pipe, scanning from head around the ring.
  always_comb begin
    rep_valid      = '0;
    scan_idx       = '0;
    o_replay_idx   = '0;
    o_replay_vaddr = '0;
    for (int p = 0; p < PIPE_N; p++) begin
      rep_idx[p] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        scan_idx = head_idx + IDX_W'(i);
        if (!rep_valid[p] && state_q[scan_idx] == ST_READY &&
            pipe_q[scan_idx] == PIPE_W'(p)) begin
          rep_valid[p] = 1'b1;
          rep_idx[p]   = scan_idx;
        end
      end
      o_replay_idx[p*IDX_W +: IDX_W] = rep_idx[p];
      if (rep_valid[p]) o_replay_vaddr[p*VADDR_W +: VADDR_W] = vaddr_q[rep_idx[p]];
    end
  end

  assign o_replay_valid = rep_valid;
  assign rep_fire       = rep_valid & i_replay_ready;

  // Next state of every entry; a same-cycle matching resolve skips the hazard state.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      state_d[e] = state_q[e];
      case (state_q[e])
        ST_FREE: begin
          for (int k = 0; k < DISP_W; k++)
            if (alloc_en && i_disp_valid[k] && disp_ptr[k][IDX_W-1:0] == IDX_W'(e))
              state_d[e] = ST_WAIT;
        end
        ST_WAIT: begin
          for (int p = 0; p < PIPE_N; p++)
            if (i_ex1_valid[p] && i_ex1_idx[p*IDX_W +: IDX_W] == IDX_W'(e)) begin
              if (i_ex1_exc[p])           state_d[e] = ST_DONE;
              else if (i_ex1_tlb_miss[p]) state_d[e] = ST_TLB_HAZ;
              else                        state_d[e] = ST_EX2_RUN;
            end
        end
        ST_EX2_RUN: begin
          for (int p = 0; p < PIPE_N; p++)
            if (i_ex2_valid[p] && i_ex2_idx[p*IDX_W +: IDX_W] == IDX_W'(e)) begin
              case (i_ex2_haz[p*2 +: 2])
                2'd0:    state_d[e] = ST_DONE;
                2'd1:    state_d[e] = ST_READY;
                2'd2:    state_d[e] = (i_lrq_resolve_valid &&
                                       |(i_lrq_resolve_oh & i_ex2_haz_oh[p*HAZ_W +: HAZ_W]))
                                      ? ST_READY : ST_LRQ_HAZ;
                default: state_d[e] = (i_stq_resolve_valid &&
                                       |(i_stq_resolve_oh & i_ex2_haz_oh[p*HAZ_W +: HAZ_W]))
                                      ? ST_READY : ST_STQ_HAZ;
              endcase
            end
        end
        ST_TLB_HAZ: if (i_tlb_resolve) state_d[e] = ST_READY;
        ST_LRQ_HAZ: if (i_lrq_resolve_valid && |(i_lrq_resolve_oh & haz_oh_q[e])) state_d[e] = ST_READY;
        ST_STQ_HAZ: if (i_stq_resolve_valid && |(i_stq_resolve_oh & haz_oh_q[e])) state_d[e] = ST_READY;
        ST_READY: begin
          for (int p = 0; p < PIPE_N; p++)
            if (rep_fire[p] && rep_idx[p] == IDX_W'(e)) state_d[e] = ST_WAIT;
        end
        ST_DONE: if (head_idx == IDX_W'(e)) state_d[e] = ST_FREE;
        default: state_d[e] = ST_FREE;
      endcase
      if (i_flush) state_d[e] = ST_FREE;
    end
  end

  // Entry states and ring pointers; flush empties the whole queue.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      head_q <= '0;
      tail_q <= '0;
      for (int e = 0; e < DEPTH; e++) state_q[e] <= ST_FREE;
    end else begin
      for (int e = 0; e < DEPTH; e++) state_q[e] <= state_d[e];
      if (i_flush) begin
        head_q <= '0;
        tail_q <= '0;
      end else begin
        tail_q <= tail_q + (alloc_en ? disp_cnt : '0);
        head_q <= head_q + PTR_W'(o_done_valid);
      end
    end
  end

  // Per-entry payload: tag at allocation, pipe/vaddr/fault at EX1, hazard index at EX2.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      exc_q <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        tag_q[e]    <= '0;
        pipe_q[e]   <= '0;
        vaddr_q[e]  <= '0;
        haz_oh_q[e] <= '0;
      end
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        for (int k = 0; k < DISP_W; k++)
          if (alloc_en && i_disp_valid[k] && state_q[e] == ST_FREE &&
              disp_ptr[k][IDX_W-1:0] == IDX_W'(e)) begin
            tag_q[e] <= i_disp_tag[k*TAG_W +: TAG_W];
            exc_q[e] <= 1'b0;
          end
        for (int p = 0; p < PIPE_N; p++) begin
          if (i_ex1_valid[p] && state_q[e] == ST_WAIT &&
              i_ex1_idx[p*IDX_W +: IDX_W] == IDX_W'(e)) begin
            pipe_q[e]  <= PIPE_W'(p);
            vaddr_q[e] <= i_ex1_vaddr[p*VADDR_W +: VADDR_W];
            exc_q[e]   <= i_ex1_exc[p];
          end
          if (i_ex2_valid[p] && state_q[e] == ST_EX2_RUN && i_ex2_haz[p*2+1] &&
              i_ex2_idx[p*IDX_W +: IDX_W] == IDX_W'(e))
            haz_oh_q[e] <= i_ex2_haz_oh[p*HAZ_W +: HAZ_W];
        end
      end
    end
  end

`ifndef SYNTHESIS
  // Simulation-only protocol checks on the upstream interfaces.
  always @(posedge i_clk) begin
    if (i_reset_n) begin
      if ((|i_disp_valid) && !o_disp_ready)
        $fatal(1, "msrh_ldq_multi: dispatch while not ready");
      if ((i_disp_valid & (i_disp_valid + DISP_W'(1))) != '0)
        $fatal(1, "msrh_ldq_multi: non-contiguous dispatch lanes");
      for (int p = 0; p < PIPE_N; p++) begin
        if (i_ex1_valid[p] && state_q[i_ex1_idx[p*IDX_W +: IDX_W]] != ST_WAIT)
          $fatal(1, "msrh_ldq_multi: EX1 to entry not in WAIT");
        if (i_ex2_valid[p] && state_q[i_ex2_idx[p*IDX_W +: IDX_W]] != ST_EX2_RUN)
          $fatal(1, "msrh_ldq_multi: EX2 to entry not in EX2_RUN");
        for (int q = p + 1; q < PIPE_N; q++) begin
          if (i_ex1_valid[p] && i_ex1_valid[q] &&
              i_ex1_idx[p*IDX_W +: IDX_W] == i_ex1_idx[q*IDX_W +: IDX_W])
            $fatal(1, "msrh_ldq_multi: two EX1 pipes hit the same entry");
          if (i_ex2_valid[p] && i_ex2_valid[q] &&
              i_ex2_idx[p*IDX_W +: IDX_W] == i_ex2_idx[q*IDX_W +: IDX_W])
            $fatal(1, "msrh_ldq_multi: two EX2 pipes hit the same entry");
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_msrh_ldq_multi.sv
// tb_msrh_ldq_multi: directed self-checking bench for msrh_ldq_multi.
module tb_msrh_ldq_multi;

  localparam int DEPTH   = 8;
  localparam int DISP_W  = 2;
  localparam int PIPE_N  = 2;
  localparam int TAG_W   = 8;
  localparam int VADDR_W = 39;
  localparam int HAZ_W   = 4;
  localparam int IDX_W   = 3;

  logic                      i_clk;
  logic                      i_reset_n;
  logic [DISP_W-1:0]         i_disp_valid;
  logic [DISP_W*TAG_W-1:0]   i_disp_tag;
  logic                      o_disp_ready;
  logic [DISP_W*IDX_W-1:0]   o_disp_idx;
  logic [PIPE_N-1:0]         i_ex1_valid;
  logic [PIPE_N*IDX_W-1:0]   i_ex1_idx;
  logic [PIPE_N*VADDR_W-1:0] i_ex1_vaddr;
  logic [PIPE_N-1:0]         i_ex1_tlb_miss;
  logic [PIPE_N-1:0]         i_ex1_exc;
  logic [PIPE_N-1:0]         i_ex2_valid;
  logic [PIPE_N*IDX_W-1:0]   i_ex2_idx;
  logic [PIPE_N*2-1:0]       i_ex2_haz;
  logic [PIPE_N*HAZ_W-1:0]   i_ex2_haz_oh;
  logic                      i_tlb_resolve;
  logic                      i_lrq_resolve_valid;
  logic [HAZ_W-1:0]          i_lrq_resolve_oh;
  logic                      i_stq_resolve_valid;
  logic [HAZ_W-1:0]          i_stq_resolve_oh;
  logic [PIPE_N-1:0]         o_replay_valid;
  logic [PIPE_N*IDX_W-1:0]   o_replay_idx;
  logic [PIPE_N*VADDR_W-1:0] o_replay_vaddr;
  logic [PIPE_N-1:0]         i_replay_ready;
  logic                      o_done_valid;
  logic [TAG_W-1:0]          o_done_tag;
  logic                      o_done_exc;
  logic                      i_flush;
  logic [IDX_W:0]            o_count;

  int tests_run    = 0;
  int tests_failed = 0;

  msrh_ldq_multi #(
    .DEPTH(DEPTH), .DISP_W(DISP_W), .PIPE_N(PIPE_N), .TAG_W(TAG_W),
    .VADDR_W(VADDR_W), .HAZ_W(HAZ_W), .IDX_W(IDX_W)
  ) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_disp_valid(i_disp_valid), .i_disp_tag(i_disp_tag),
    .o_disp_ready(o_disp_ready), .o_disp_idx(o_disp_idx),
    .i_ex1_valid(i_ex1_valid), .i_ex1_idx(i_ex1_idx), .i_ex1_vaddr(i_ex1_vaddr),
    .i_ex1_tlb_miss(i_ex1_tlb_miss), .i_ex1_exc(i_ex1_exc),
    .i_ex2_valid(i_ex2_valid), .i_ex2_idx(i_ex2_idx), .i_ex2_haz(i_ex2_haz),
    .i_ex2_haz_oh(i_ex2_haz_oh), .i_tlb_resolve(i_tlb_resolve),
    .i_lrq_resolve_valid(i_lrq_resolve_valid), .i_lrq_resolve_oh(i_lrq_resolve_oh),
    .i_stq_resolve_valid(i_stq_resolve_valid), .i_stq_resolve_oh(i_stq_resolve_oh),
    .o_replay_valid(o_replay_valid), .o_replay_idx(o_replay_idx),
    .o_replay_vaddr(o_replay_vaddr), .i_replay_ready(i_replay_ready),
    .o_done_valid(o_done_valid), .o_done_tag(o_done_tag), .o_done_exc(o_done_exc),
    .i_flush(i_flush), .o_count(o_count)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Watchdog so a stuck run still ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic clear_inputs();
    i_disp_valid        = '0;
    i_disp_tag          = '0;
    i_ex1_valid         = '0;
    i_ex1_idx           = '0;
    i_ex1_vaddr         = '0;
    i_ex1_tlb_miss      = '0;
    i_ex1_exc           = '0;
    i_ex2_valid         = '0;
    i_ex2_idx           = '0;
    i_ex2_haz           = '0;
    i_ex2_haz_oh        = '0;
    i_tlb_resolve       = 1'b0;
    i_lrq_resolve_valid = 1'b0;
    i_lrq_resolve_oh    = '0;
    i_stq_resolve_valid = 1'b0;
    i_stq_resolve_oh    = '0;
    i_replay_ready      = '0;
    i_flush             = 1'b0;
  endtask

  task automatic do_dispatch(input logic [1:0] v, input logic [7:0] t0, input logic [7:0] t1);
    i_disp_valid = v;
    i_disp_tag   = {t1, t0};
    applyStimulus(1);
    clear_inputs();
  endtask

  task automatic set_ex1(input int p, input logic [IDX_W-1:0] idx,
                         input logic [VADDR_W-1:0] va, input logic tlb, input logic exc);
    i_ex1_valid[p]                     = 1'b1;
    i_ex1_idx[p*IDX_W +: IDX_W]        = idx;
    i_ex1_vaddr[p*VADDR_W +: VADDR_W]  = va;
    i_ex1_tlb_miss[p]                  = tlb;
    i_ex1_exc[p]                       = exc;
  endtask

  task automatic set_ex2(input int p, input logic [IDX_W-1:0] idx,
                         input logic [1:0] haz, input logic [HAZ_W-1:0] oh);
    i_ex2_valid[p]                  = 1'b1;
    i_ex2_idx[p*IDX_W +: IDX_W]     = idx;
    i_ex2_haz[p*2 +: 2]             = haz;
    i_ex2_haz_oh[p*HAZ_W +: HAZ_W]  = oh;
  endtask

  initial begin
    clear_inputs();
    i_reset_n = 1'b0;
    #12;
    checkOutput("rst_count",        64'(o_count),        64'd0);
    checkOutput("rst_disp_ready",   64'(o_disp_ready),   64'd1);
    checkOutput("rst_done_valid",   64'(o_done_valid),   64'd0);
    checkOutput("rst_replay_valid", 64'(o_replay_valid), 64'd0);
    checkOutput("rst_disp_idx",     64'(o_disp_idx),     64'd8);
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;

    // Two loads straight through without hazards
    i_disp_valid = 2'b11;
    i_disp_tag   = {8'h11, 8'h10};
    #1;
    checkOutput("t1_disp_idx", 64'(o_disp_idx), 64'd8);
    applyStimulus(1);
    clear_inputs();
    checkOutput("t1_count2", 64'(o_count), 64'd2);
    set_ex1(0, 3'd0, 39'h1000, 1'b0, 1'b0);
    set_ex1(1, 3'd1, 39'h2000, 1'b0, 1'b0);
    applyStimulus(1);
    clear_inputs();
    checkOutput("t1_no_done_yet", 64'(o_done_valid), 64'd0);
    set_ex2(0, 3'd0, 2'd0, 4'b0000);
    set_ex2(1, 3'd1, 2'd0, 4'b0000);
    applyStimulus(1);
    clear_inputs();
    checkOutput("t1_done0_valid", 64'(o_done_valid), 64'd1);
    checkOutput("t1_done0_tag",   64'(o_done_tag),   64'h10);
    checkOutput("t1_done0_exc",   64'(o_done_exc),   64'd0);
    applyStimulus(1);
    checkOutput("t1_done1_valid", 64'(o_done_valid), 64'd1);
    checkOutput("t1_done1_tag",   64'(o_done_tag),   64'h11);
    checkOutput("t1_count1",      64'(o_count),      64'd1);
    applyStimulus(1);
    checkOutput("t1_idle_done",   64'(o_done_valid), 64'd0);
    checkOutput("t1_count0",      64'(o_count),      64'd0);

    // Flush an empty queue to bring the pointers back to zero
    i_flush = 1'b1;
    applyStimulus(1);
    clear_inputs();
    checkOutput("fl0_count",    64'(o_count),    64'd0);
    checkOutput("fl0_disp_idx", 64'(o_disp_idx), 64'd8);

    // Fill to DEPTH, then drain two to reopen dispatch
    do_dispatch(2'b11, 8'h20, 8'h21);
    do_dispatch(2'b11, 8'h22, 8'h23);
    do_dispatch(2'b11, 8'h24, 8'h25);
    checkOutput("fill_count6", 64'(o_count),      64'd6);
    checkOutput("fill_ready6", 64'(o_disp_ready), 64'd1);
    do_dispatch(2'b11, 8'h26, 8'h27);
    checkOutput("fill_count8", 64'(o_count),      64'd8);
    checkOutput("fill_ready8", 64'(o_disp_ready), 64'd0);
    set_ex1(0, 3'd0, 39'h100, 1'b0, 1'b0);
    set_ex1(1, 3'd1, 39'h200, 1'b0, 1'b0);
    applyStimulus(1);
    clear_inputs();
    set_ex2(0, 3'd0, 2'd0, 4'b0000);
    set_ex2(1, 3'd1, 2'd0, 4'b0000);
    applyStimulus(1);
    clear_inputs();
    checkOutput("fill_done20",    64'(o_done_tag),   64'h20);
    checkOutput("fill_count8b",   64'(o_count),      64'd8);
    applyStimulus(1);
    checkOutput("fill_count7",    64'(o_count),      64'd7);
    checkOutput("fill_ready7",    64'(o_disp_ready), 64'd0);
    checkOutput("fill_done21",    64'(o_done_tag),   64'h21);
    applyStimulus(1);
    checkOutput("fill_count6b",   64'(o_count),      64'd6);
    checkOutput("fill_ready6b",   64'(o_disp_ready), 64'd1);
    checkOutput("fill_wrap_idx",  64'(o_disp_idx),   64'd8);
    checkOutput("fill_idle_done", 64'(o_done_valid), 64'd0);

    // Faulting load at the head (entry 2, tag 0x22)
    set_ex1(0, 3'd2, 39'h2222, 1'b0, 1'b1);
    applyStimulus(1);
    clear_inputs();
    checkOutput("exc_done_valid", 64'(o_done_valid), 64'd1);
    checkOutput("exc_done_tag",   64'(o_done_tag),   64'h22);
    checkOutput("exc_done_exc",   64'(o_done_exc),   64'd1);
    applyStimulus(1);
    checkOutput("exc_count5",     64'(o_count),      64'd5);

    // LRQ hazard on entry 3 through pipe 1, wrong then right resolve
    set_ex1(1, 3'd3, 39'h3333, 1'b0, 1'b0);
    applyStimulus(1);
    clear_inputs();
    set_ex2(1, 3'd3, 2'd2, 4'b0100);
    applyStimulus(1);
    clear_inputs();
    checkOutput("lrq_wait_norep", 64'(o_replay_valid), 64'd0);
    i_lrq_resolve_valid = 1'b1;
    i_lrq_resolve_oh    = 4'b0010;
    applyStimulus(1);
    clear_inputs();
    checkOutput("lrq_wrong_oh", 64'(o_replay_valid), 64'd0);
    i_lrq_resolve_valid = 1'b1;
    i_lrq_resolve_oh    = 4'b0100;
    applyStimulus(1);
    clear_inputs();
    checkOutput("lrq_rep_valid", 64'(o_replay_valid), 64'b10);
    checkOutput("lrq_rep_idx",   64'(o_replay_idx),   64'd24);
    checkOutput("lrq_rep_vaddr", 64'(o_replay_vaddr[VADDR_W +: VADDR_W]), 64'h3333);
    applyStimulus(3);
    checkOutput("lrq_hold_valid", 64'(o_replay_valid), 64'b10);
    checkOutput("lrq_hold_idx",   64'(o_replay_idx),   64'd24);
    i_replay_ready = 2'b10;
    applyStimulus(1);
    clear_inputs();
    checkOutput("lrq_accepted", 64'(o_replay_valid), 64'd0);

    // STQ hazard resolved in the same cycle it is reported (entry 6, pipe 1)
    set_ex1(1, 3'd6, 39'h6666, 1'b0, 1'b0);
    applyStimulus(1);
    clear_inputs();
    set_ex2(1, 3'd6, 2'd3, 4'b0001);
    i_stq_resolve_valid = 1'b1;
    i_stq_resolve_oh    = 4'b0001;
    applyStimulus(1);
    clear_inputs();
    checkOutput("stq_same_valid", 64'(o_replay_valid), 64'b10);
    checkOutput("stq_same_idx",   64'(o_replay_idx),   64'd48);

    // Retire entry 3 so head moves to 4
    set_ex1(0, 3'd3, 39'h3000, 1'b0, 1'b0);
    applyStimulus(1);
    clear_inputs();
    set_ex2(0, 3'd3, 2'd0, 4'b0000);
    applyStimulus(1);
    clear_inputs();
    checkOutput("ret3_tag", 64'(o_done_tag), 64'h23);
    applyStimulus(1);
    checkOutput("ret3_count4", 64'(o_count), 64'd4);

    // Wrap allocation into entries 0 and 1
    do_dispatch(2'b11, 8'h28, 8'h29);
    checkOutput("wrap_count6", 64'(o_count), 64'd6);

    // Entries 1 and 5 both READY on pipe 0: entry 5 is older from head 4
    set_ex1(0, 3'd1, 39'h1111, 1'b0, 1'b0);
    applyStimulus(1);
    clear_inputs();
    set_ex2(0, 3'd1, 2'd1, 4'b0000);
    set_ex1(0, 3'd5, 39'h5555, 1'b0, 1'b0);
    applyStimulus(1);
    clear_inputs();
    checkOutput("arb_one_valid", 64'(o_replay_valid), 64'b11);
    checkOutput("arb_one_idx",   64'(o_replay_idx),   64'd49);
    set_ex2(0, 3'd5, 2'd1, 4'b0000);
    applyStimulus(1);
    clear_inputs();
    checkOutput("arb_old_idx",   64'(o_replay_idx), 64'd53);
    checkOutput("arb_old_vaddr", 64'(o_replay_vaddr[0 +: VADDR_W]), 64'h5555);
    i_replay_ready = 2'b01;
    applyStimulus(1);
    clear_inputs();
    checkOutput("arb_next_idx",   64'(o_replay_idx), 64'd49);
    checkOutput("arb_next_vaddr", 64'(o_replay_vaddr[0 +: VADDR_W]), 64'h1111);

    // Flush with live entries overrides dispatch and replay acceptance
    i_flush        = 1'b1;
    i_disp_valid   = 2'b11;
    i_disp_tag     = {8'h99, 8'h98};
    i_replay_ready = 2'b11;
    applyStimulus(1);
    clear_inputs();
    checkOutput("fl_count",    64'(o_count),        64'd0);
    checkOutput("fl_no_rep",   64'(o_replay_valid), 64'd0);
    checkOutput("fl_no_done",  64'(o_done_valid),   64'd0);
    checkOutput("fl_disp_idx", 64'(o_disp_idx),     64'd8);

    // TLB miss, refill, replay, then normal completion
    do_dispatch(2'b01, 8'h30, 8'h00);
    checkOutput("tlb_count1", 64'(o_count), 64'd1);
    set_ex1(1, 3'd0, 39'h7777, 1'b1, 1'b0);
    applyStimulus(1);
    clear_inputs();
    checkOutput("tlb_wait_norep", 64'(o_replay_valid), 64'd0);
    i_tlb_resolve = 1'b1;
    applyStimulus(1);
    clear_inputs();
    checkOutput("tlb_rep_valid", 64'(o_replay_valid), 64'b10);
    checkOutput("tlb_rep_idx",   64'(o_replay_idx),   64'd0);
    checkOutput("tlb_rep_vaddr", 64'(o_replay_vaddr[VADDR_W +: VADDR_W]), 64'h7777);
    i_replay_ready = 2'b10;
    applyStimulus(1);
    clear_inputs();
    checkOutput("tlb_accepted", 64'(o_replay_valid), 64'd0);
    set_ex1(1, 3'd0, 39'h7777, 1'b0, 1'b0);
    applyStimulus(1);
    clear_inputs();
    set_ex2(1, 3'd0, 2'd0, 4'b0000);
    applyStimulus(1);
    clear_inputs();
    checkOutput("tlb_done_tag", 64'(o_done_tag), 64'h30);
    applyStimulus(1);
    checkOutput("tlb_count0", 64'(o_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
